// File: rtl/slave_interface_pkg.sv
// Shared definitions for the serial-bus slave: FSM states, transfer modes and bit order.
package slave_interface_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StMemWr,
    StMemRd,
    StRdata
  } slave_state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Serial fields travel least-significant bit first on both directions of the bus.
  localparam bit LSB_FIRST = 1'b1;

  // Position within a width-bit word of the idx-th serial bit.
  function automatic int unsigned bit_pos(input int unsigned idx, input int unsigned width);
    return LSB_FIRST ? idx : width - 1 - idx;
  endfunction

endpackage

// File: rtl/slave_interface_if.sv
// Serial bus signals between the bus fabric (master side) and one slave port.
interface slave_interface_if;
  logic swdata;
  logic smode;
  logic swvalid;
  logic srdata;
  logic srvalid;
  logic sready;

  modport master (
    output swdata, smode, swvalid,
    input  srdata, srvalid, sready
  );

  modport slave (
    input  swdata, smode, swvalid,
    output srdata, srvalid, sready
  );
endinterface

// File: rtl/slave_interface.sv
// Serial-bus responder: deserialises address/write data into parallel memory accesses and
// serialises read data back onto the bus.
module slave_interface
  import slave_interface_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_interface_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntW = $clog2(MaxW);

  slave_state_e          r_state;
  logic [CntW-1:0]       r_cnt;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_wen;
  logic                  r_mem_ren;
  logic                  r_srdata;
  logic                  r_srvalid;

  logic                  w_sready;
  logic                  w_accept;
  logic                  w_addr_last;
  logic                  w_data_last;
  logic [ADDR_WIDTH-1:0] w_addr_full;
  logic [DATA_WIDTH-1:0] w_data_full;

  assign w_sready    = (r_state == StIdle) || (r_state == StAddr) || (r_state == StWdata);
  assign w_accept    = bus.swvalid && w_sready;
  assign w_addr_last = (r_cnt == CntW'(ADDR_WIDTH - 1));
  assign w_data_last = (r_cnt == CntW'(DATA_WIDTH - 1));

  // Complete words including the bit arriving this cycle, so the last bit needs no extra cycle.
  always_comb begin
    w_addr_full = r_addr;
    w_addr_full[bit_pos(ADDR_WIDTH - 1, ADDR_WIDTH)] = bus.swdata;
    w_data_full = r_data;
    w_data_full[bit_pos(DATA_WIDTH - 1, DATA_WIDTH)] = bus.swdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mode      <= MODE_READ;
      r_addr      <= '0;
      r_data      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_srdata    <= 1'b0;
      r_srvalid   <= 1'b0;
    end else begin
      r_mem_wen <= 1'b0;
      r_mem_ren <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_addr[bit_pos(0, ADDR_WIDTH)] <= bus.swdata;
            r_mode  <= bus.smode;
            r_cnt   <= CntW'(1);
            r_state <= StAddr;
          end
        end
        StAddr: begin
          if (w_accept) begin
            if (w_addr_last) begin
              r_cnt      <= '0;
              r_mem_addr <= w_addr_full;
              if (r_mode == MODE_WRITE) begin
                r_state <= StWdata;
              end else begin
                r_state   <= StMemRd;
                r_mem_ren <= 1'b1;
              end
            end else begin
              r_addr[bit_pos(32'(r_cnt), ADDR_WIDTH)] <= bus.swdata;
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        StWdata: begin
          if (w_accept) begin
            if (w_data_last) begin
              r_cnt       <= '0;
              r_mem_wdata <= w_data_full;
              r_mem_wen   <= 1'b1;
              r_state     <= StMemWr;
            end else begin
              r_data[bit_pos(32'(r_cnt), DATA_WIDTH)] <= bus.swdata;
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        StMemWr: begin
          r_state <= StIdle;
        end
        StMemRd: begin
          if (mem_rvalid) begin
            r_data    <= mem_rdata;
            r_srdata  <= mem_rdata[bit_pos(0, DATA_WIDTH)];
            r_srvalid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= StRdata;
          end
        end
        StRdata: begin
          if (w_data_last) begin
            r_srdata  <= 1'b0;
            r_srvalid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= StIdle;
          end else begin
            r_srdata <= r_data[bit_pos(32'(r_cnt) + 1, DATA_WIDTH)];
            r_cnt    <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.sready  = w_sready;
  assign bus.srdata  = r_srdata;
  assign bus.srvalid = r_srvalid;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wen     = r_mem_wen;
  assign mem_ren     = r_mem_ren;

endmodule

// File: tb/tb_slave_interface.sv
// Directed plus randomized bench for slave_interface with a reference memory and bus driver.
module tb_slave_interface;
  import slave_interface_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  slave_interface_if sif ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_wen;
  logic          mem_ren;
  logic          mem_rvalid = 1'b0;

  slave_interface #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (sif),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  int checks = 0;
  int errors = 0;

  // Memory attached to the DUT, and the bench's own record of what memory should hold.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem   [0:(1<<AW)-1];

  int          wen_cnt = 0;
  int          ren_cnt = 0;
  int          rd_lat  = 2;
  int          rd_wait = 0;
  logic [AW-1:0] rd_addr = '0;
  bit          stray   = 1'b0;

  always @(negedge clk) begin : mem_resp
    logic rv;
    rv = 1'b0;
    if (!rstn) begin
      rd_wait = 0;
    end else begin
      if (mem_wen) begin
        mem_model[mem_addr] = mem_wdata;
        wen_cnt++;
      end
      if (mem_ren) begin
        rd_wait = rd_lat;
        rd_addr = mem_addr;
        ren_cnt++;
      end else if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          rv        = 1'b1;
          mem_rdata = mem_model[rd_addr];
        end
      end
      if (stray) begin
        rv        = 1'b1;
        mem_rdata = 8'h5A;
        stray     = 1'b0;
      end
    end
    mem_rvalid = rv;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives n bits LSB first from the current negedge; optional fixed and random idle gaps.
  task automatic send_bits(input logic [31:0] val, input int n, input logic mode,
                           input int gap_at, input int gap_len, input bit rnd);
    for (int i = 0; i < n; i++) begin
      check("sready_in", 32'(sif.sready), 32'd1);
      sif.swvalid = 1'b1;
      sif.swdata  = val[i];
      sif.smode   = (i == 0) ? mode : ~mode;
      @(negedge clk);
      sif.swvalid = 1'b0;
      sif.swdata  = 1'($urandom);
      sif.smode   = 1'($urandom);
      if (i < n - 1) begin
        int g;
        g = (i == gap_at) ? gap_len : ((rnd && $urandom_range(0, 3) == 0) ?
            int'($urandom_range(1, 3)) : 0);
        repeat (g) begin
          check("no_strobe_gap", 32'({mem_wen, mem_ren}), 32'd0);
          @(negedge clk);
        end
      end
    end
  endtask

  // gap_kind: 0 contiguous, 1 fixed gaps after addr bit 5 / data bit 3, 2 random gaps.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int gap_kind);
    send_bits(32'(addr), AW, MODE_WRITE, (gap_kind == 1) ? 5 : -1, 3, gap_kind == 2);
    send_bits(32'(data), DW, MODE_WRITE, (gap_kind == 1) ? 3 : -1, 2, gap_kind == 2);
    check("wen", 32'(mem_wen), 32'd1);
    check("waddr", 32'(mem_addr), 32'(addr));
    check("wdata", 32'(mem_wdata), 32'(data));
    check("sready_wr", 32'(sif.sready), 32'd0);
    ref_mem[addr] = data;
    @(negedge clk);
    check("wen_pulse", 32'(mem_wen), 32'd0);
    check("sready_after_wr", 32'(sif.sready), 32'd1);
  endtask

  // abort_after >= 0 pulls reset after that many serial read bits.
  task automatic do_read(input logic [AW-1:0] addr, input int lat, input bit busy,
                         input int abort_after);
    int d;
    int ren0;
    logic [DW-1:0] exp;
    exp    = ref_mem[addr];
    rd_lat = lat;
    ren0   = ren_cnt;
    send_bits(32'(addr), AW, MODE_READ, -1, 0, 1'b1);
    check("ren", 32'(mem_ren), 32'd1);
    check("raddr", 32'(mem_addr), 32'(addr));
    check("sready_rd", 32'(sif.sready), 32'd0);
    if (busy) begin
      sif.swvalid = 1'b1;
      sif.swdata  = 1'b1;
      sif.smode   = 1'b1;
    end
    d = 0;
    while (sif.srvalid !== 1'b1 && d < 20) begin
      @(negedge clk);
      d++;
      if (d == 1) check("ren_pulse", 32'(mem_ren), 32'd0);
    end
    sif.swvalid = 1'b0;
    check("rd_latency", 32'(d), 32'(lat + 1));
    for (int i = 0; i < int'(DW); i++) begin
      if (i == abort_after) begin
        rstn = 1'b0;
        #1;
        check("abort_srvalid", 32'(sif.srvalid), 32'd0);
        check("abort_srdata", 32'(sif.srdata), 32'd0);
        check("abort_sready", 32'(sif.sready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        return;
      end
      check("srvalid", 32'(sif.srvalid), 32'd1);
      check("srdata", 32'(sif.srdata), 32'(exp[i]));
      @(negedge clk);
    end
    check("srvalid_end", 32'(sif.srvalid), 32'd0);
    check("srdata_end", 32'(sif.srdata), 32'd0);
    check("sready_end", 32'(sif.sready), 32'd1);
    check("ren_count", 32'(ren_cnt - ren0), 32'd1);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem_model[i] = '0;
      ref_mem[i]   = '0;
    end
    rstn        = 1'b0;
    sif.swvalid = 1'b1;
    sif.swdata  = 1'b1;
    sif.smode   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sready", 32'(sif.sready), 32'd1);
    check("rst_srvalid", 32'(sif.srvalid), 32'd0);
    check("rst_srdata", 32'(sif.srdata), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    sif.swvalid = 1'b0;
    rstn        = 1'b1;
    @(negedge clk);

    do_write(12'h0A5, 8'h3C, 0);
    do_read(12'h0A5, 2, 1'b0, -1);
    do_write(12'h0A5, 8'h3C, 1);
    do_read(12'h0A5, 3, 1'b1, -1);

    // Stray read-valid while idle must not disturb anything.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_sready", 32'(sif.sready), 32'd1);
    check("stray_srvalid", 32'(sif.srvalid), 32'd0);

    do_read(12'h0A5, 1, 1'b0, 3);
    check("post_abort_sready", 32'(sif.sready), 32'd1);
    do_write(12'h001, 8'hFF, 0);
    do_read(12'h001, 2, 1'b0, -1);

    // Reset in the middle of write data: no strobe, partial word discarded.
    w0 = wen_cnt;
    send_bits(32'h0000_0777, AW, MODE_WRITE, -1, 0, 1'b0);
    send_bits(32'h0000_0009, 4, MODE_WRITE, -1, 0, 1'b0);
    rstn = 1'b0;
    #1;
    check("abortw_sready", 32'(sif.sready), 32'd1);
    check("abortw_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("abortw_no_wen", 32'(wen_cnt - w0), 32'd0);
    do_read(12'h777, 2, 1'b0, -1);

    do_write(12'hFFF, 8'h81, 0);
    do_write(12'h000, 8'h7E, 2);
    do_read(12'hFFF, 4, 1'b1, -1);
    do_read(12'h000, 1, 1'b0, -1);

    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      a = (t % 3 == 0) ? 12'h0A5 : AW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, DW'($urandom), 2);
      end else begin
        do_read(a, int'($urandom_range(1, 4)), 1'($urandom), -1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
